// File: rtl/sound_scheduler.sv
// Tone sequencer: latches ping/pong/go/stop requests, plays them one at a time for DUR
// cycles, then mutes for GAP cycles. Stop preempts a playing tone; lost requests are counted.
module sound_scheduler #(
    parameter int unsigned DUR = 1250000,
    parameter int unsigned GAP = 250000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sound_en,
    input  logic [3:0] req,
    output logic       mute,
    output logic [1:0] code_sound,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    localparam logic [23:0] DUR_M1 = 24'(DUR - 1);
    localparam logic [23:0] GAP_M1 = 24'(GAP - 1);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  code_q, code_d;
    logic        mute_q, mute_d;
    logic        busy_q, busy_d;
    logic [7:0]  drop_q, drop_d;

    logic [1:0]  grant_idx;
    logic [3:0]  clear;
    logic [3:0]  dup;
    logic        preempt;
    logic [2:0]  n_drop;
    logic [8:0]  drop_sum;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        mute_d    = mute_q;
        busy_d    = busy_q;
        clear     = '0;
        preempt   = 1'b0;
        grant_idx = 2'd0;
        n_drop    = '0;

        if (pending_q[3])      grant_idx = 2'd3;
        else if (pending_q[2]) grant_idx = 2'd2;
        else if (pending_q[1]) grant_idx = 2'd1;
        else                   grant_idx = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    code_d           = grant_idx;
                    mute_d           = 1'b0;
                    busy_d           = 1'b1;
                    cnt_d            = DUR_M1;
                    state_d          = S_PLAY;
                    clear[grant_idx] = 1'b1;
                end
            end
            S_PLAY: begin
                // Stop preemption is checked before expiry so it wins on the last play cycle.
                if (code_q != 2'd3 && pending_q[3]) begin
                    code_d   = 2'd3;
                    cnt_d    = DUR_M1;
                    clear[3] = 1'b1;
                    preempt  = 1'b1;
                end else if (cnt_q == '0) begin
                    mute_d  = 1'b1;
                    cnt_d   = GAP_M1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new request on a bit being granted this edge re-arms it rather than being lost.
        dup       = req & pending_q & ~clear;
        pending_d = (pending_q & ~clear) | req;

        n_drop = {2'b00, preempt};
        for (int unsigned i = 0; i < 4; i++) begin
            n_drop = n_drop + {2'b00, dup[i]};
        end
        drop_sum = {1'b0, drop_q} + {6'd0, n_drop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

        if (!sound_en) begin
            state_d   = S_IDLE;
            mute_d    = 1'b1;
            busy_d    = 1'b0;
            pending_d = '0;
            cnt_d     = '0;
            code_d    = code_q;
            drop_d    = drop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            mute_q    <= 1'b1;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            mute_q    <= mute_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign mute       = mute_q;
    assign code_sound = code_q;
    assign busy       = busy_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: directed scenarios plus random traffic, every cycle compared
// against a timeline model that derives outputs from the cycle a tone started.
module tb_sound_scheduler;

    localparam int DUR = 8;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       clr;
    logic       sound_en;
    logic [3:0] req;
    logic       mute;
    logic [1:0] code_sound;
    logic       busy;
    logic [7:0] drop_cnt;

    sound_scheduler #(.DUR(DUR), .GAP(GAP)) dut (
        .clk        (clk),
        .clr        (clr),
        .sound_en   (sound_en),
        .req        (req),
        .mute       (mute),
        .code_sound (code_sound),
        .busy       (busy),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Model: a tone is described by the edge index at which it started; the phase
    // (playing, gap, idle) follows from how many edges have elapsed since then.
    longint  cyc     = 0;
    bit      m_active;
    longint  m_start;
    int      m_code;
    int      m_drop;
    bit [3:0] m_pend;

    task automatic model_step(input bit c, input bit en, input bit [3:0] r);
        longint e;
        bit idle_before, play_before;
        bit [3:0] cleared;
        int drops;
        int g;
        cyc++;
        if (c) begin
            m_active = 0; m_code = 0; m_drop = 0; m_pend = '0;
        end else if (!en) begin
            m_active = 0; m_pend = '0;
        end else begin
            cleared = '0;
            drops   = 0;
            e = cyc - m_start;
            idle_before = !m_active || (e >= DUR + GAP + 1);
            play_before = m_active && e >= 1 && e <= DUR;
            if (idle_before && m_pend != 0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (m_pend[i]) g = i;
                m_active = 1; m_start = cyc; m_code = g; cleared[g] = 1;
            end else if (play_before && m_code != 3 && m_pend[3]) begin
                m_start = cyc; m_code = 3; cleared[3] = 1; drops++;
            end
            for (int i = 0; i < 4; i++)
                if (r[i] && m_pend[i] && !cleared[i]) drops++;
            m_pend = (m_pend & ~cleared) | r;
            m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        end
    endtask

    task automatic compare_outputs();
        longint e;
        int exp_mute, exp_busy;
        exp_mute = 1; exp_busy = 0;
        if (m_active) begin
            e = cyc - m_start;
            if (e < DUR)            begin exp_mute = 0; exp_busy = 1; end
            else if (e < DUR + GAP) begin exp_mute = 1; exp_busy = 1; end
        end
        check("mute", int'(mute), exp_mute);
        check("busy", int'(busy), exp_busy);
        check("code", int'(code_sound), m_code);
        check("drop", int'(drop_cnt), m_drop);
    endtask

    task automatic tick(input bit c, input bit en, input bit [3:0] r);
        clr = c; sound_en = en; req = r;
        @(posedge clk);
        model_step(c, en, r);
        #1;
        compare_outputs();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 4'b0000);
    endtask

    initial begin
        clr = 1'b1; sound_en = 1'b1; req = '0;
        m_active = 0; m_start = 0; m_code = 0; m_drop = 0; m_pend = '0;

        // Reset state
        tick(1'b1, 1'b1, 4'b0000);
        tick(1'b1, 1'b1, 4'b1111);
        check("rst_mute", int'(mute), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_code", int'(code_sound), 0);
        check("rst_drop", int'(drop_cnt), 0);

        // Single ping: audible after one edge, muted after DUR+1, idle after DUR+GAP+1
        tick(1'b0, 1'b1, 4'b0001);
        tick(1'b0, 1'b1, 4'b0000);
        check("ping_start_mute", int'(mute), 0);
        idle_ticks(7);
        check("ping_last_play", int'(mute), 0);
        tick(1'b0, 1'b1, 4'b0000);
        check("ping_gap_mute", int'(mute), 1);
        check("ping_gap_busy", int'(busy), 1);
        idle_ticks(2);
        check("ping_idle_busy", int'(busy), 0);
        idle_ticks(2);

        // go + pong together: go first, pong after gap and idle cycle
        tick(1'b0, 1'b1, 4'b0110);
        idle_ticks(1);
        check("pair_first", int'(code_sound), 2);
        idle_ticks(10);
        check("pair_waiting", int'(busy), 0);
        idle_ticks(1);
        check("pair_second", int'(code_sound), 1);
        check("pair_drop", int'(drop_cnt), 0);
        idle_ticks(12);

        // Stop preempts a ping on its third play cycle
        tick(1'b0, 1'b1, 4'b0001);
        idle_ticks(3);
        tick(1'b0, 1'b1, 4'b1000);
        tick(1'b0, 1'b1, 4'b0000);
        check("preempt_code", int'(code_sound), 3);
        check("preempt_drop", int'(drop_cnt), 1);
        idle_ticks(14);

        // Repeated pong during ping, then a long duplicate burst to saturate
        tick(1'b0, 1'b1, 4'b0001);
        idle_ticks(1);
        tick(1'b0, 1'b1, 4'b0010);
        tick(1'b0, 1'b1, 4'b0010);
        tick(1'b0, 1'b1, 4'b0010);
        idle_ticks(30);
        check("dup_drop", int'(drop_cnt), 3);
        for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 4'b0010);
        check("sat_drop", int'(drop_cnt), 255);
        idle_ticks(30);

        // clr during GAP with ping and go pending
        tick(1'b1, 1'b1, 4'b0000);
        tick(1'b0, 1'b1, 4'b0001);
        idle_ticks(2);
        tick(1'b0, 1'b1, 4'b0101);
        idle_ticks(7);
        check("clr_in_gap", int'(busy), 1);
        tick(1'b1, 1'b1, 4'b0000);
        check("clr_busy", int'(busy), 0);
        check("clr_drop", int'(drop_cnt), 0);
        idle_ticks(15);
        check("clr_no_tone", int'(busy), 0);

        // sound_en low during stop tone with stop pending
        tick(1'b0, 1'b1, 4'b1000);
        idle_ticks(2);
        tick(1'b0, 1'b1, 4'b1000);
        tick(1'b0, 1'b0, 4'b0000);
        check("en_off_mute", int'(mute), 1);
        check("en_off_code", int'(code_sound), 3);
        idle_ticks(15);
        check("en_off_stays_idle", int'(busy), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit [3:0] r;
            bit c, en;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(9, 0) == 0);
            c  = ($urandom_range(399, 0) == 0);
            en = ($urandom_range(59, 0) != 0);
            tick(c, en, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter DUR, default 1250000, SHALL set tone length in clk cycles (legal range 1 to 2^24-1).
REQ-002 Parameter GAP, default 250000, SHALL set the muted gap between tones in clk cycles (legal range 1 to 2^24-1).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 clr  in  1  reset; synchronous, active-high.
REQ-005 sound_en  in  1  global enable; 0 SHALL silence the block and discard requests.
REQ-006 req  in  4  one-cycle sound request strobes: bit0 ping, bit1 pong, bit2 go, bit3 stop.
REQ-007 mute  out  1  registered; 1 = silence.
REQ-008 code_sound  out  2  registered; sound code for the tone generator: 0 ping, 1 pong, 2 go, 3 stop.
REQ-009 busy  out  1  registered; 1 in states PLAY and GAP.
REQ-010 drop_cnt  out  8  registered saturating count of lost requests.

Function
REQ-011 State machine SHALL have the states IDLE, PLAY and GAP, held in one state register.
REQ-012 pending[3:0] SHALL latch req bits: req[i]=1 at edge k sets pending[i] at edge k.
REQ-013 Duplicate request: if req[i]=1 while pending[i]=1 and pending[i] is not cleared that edge, drop_cnt SHALL increment.
REQ-014 IDLE with pending!=0 SHALL grant the highest set bit (priority stop>go>pong>ping) at the next edge: code_sound=index, mute=0, busy=1, counter=DUR-1, state PLAY, and the granted pending bit cleared.
REQ-015 Latency: req[i] high at edge k in IDLE with pending=0 SHALL give mute=0 and code_sound=i after edge k+1.
REQ-016 Simultaneous grant and new request on the same bit: the request SHALL win, so the bit stays pending and drop_cnt does not increment.
REQ-017 PLAY: counter SHALL decrement each cycle; at counter=0, the next edge SHALL set mute=1, counter=GAP-1 and state GAP, and code_sound SHALL hold its value.
REQ-018 Preemption: in PLAY with code_sound!=3 and pending[3]=1, the next edge SHALL set code_sound=3, counter=DUR-1, clear pending[3] and stay in PLAY with mute=0.
REQ-019 The preempted tone SHALL be discarded, and drop_cnt SHALL increment once.
REQ-020 Preemption SHALL take precedence over PLAY expiry in the same cycle.
REQ-021 GAP: counter SHALL decrement; at counter=0, the next edge SHALL enter IDLE with busy=0. Grant from IDLE SHALL happen one cycle later, so the minimum spacing between tone starts is DUR+GAP+1 cycles.
REQ-022 Requests arriving in PLAY or GAP SHALL remain pending and be served in priority order after GAP.
REQ-023 drop_cnt SHALL saturate at 255.
REQ-024 When several drop events occur in one cycle, drop_cnt SHALL add their count, clipped at 255.
REQ-025 sound_en=0 at an edge SHALL force state IDLE, mute=1, busy=0 and pending=0, and SHALL ignore req.
REQ-026 While sound_en=0, code_sound and drop_cnt SHALL hold their values.
REQ-027 The counter SHALL be 24 bits wide, and no output SHALL glitch combinationally.

Reset
REQ-028 clr=1 at an edge SHALL set state=IDLE, mute=1, code_sound=0, busy=0, pending=0, counter=0 and drop_cnt=0.
REQ-029 clr SHALL take priority over sound_en and req, including mid-PLAY and mid-GAP.
REQ-030 The first grant after clr deassertion SHALL follow REQ-015.

Verification (bench uses DUR=8, GAP=2)
REQ-031 req=0001 for one cycle at edge 0 -> mute=0 and code=0 after edge 1 -> mute=1 after edge 9 -> busy=0 after edge 11.
REQ-032 req=0110 at one edge -> code=2 plays for 8 cycles -> 2-cycle gap -> 1 idle cycle -> code=1 plays; drop_cnt=0.
REQ-033 During code=0 PLAY, at its 3rd cycle, req=1000 -> code=3 and mute=0 one edge later, full 8-cycle tone; drop_cnt=1.
REQ-034 req=0010 pulsed on three edges during PLAY of code=0 -> pong plays once; drop_cnt=2. Then 300 duplicate pulses -> drop_cnt=255, no wrap.
REQ-035 clr=1 mid-GAP with pending=0101 -> all outputs at reset values next edge; no tone follows without new req.
REQ-036 sound_en=0 for 1 cycle during PLAY with pending=1000 -> mute=1, busy=0, pending cleared; sound_en=1 with no req -> stays IDLE.
